// File: rtl/led_pkg.sv
// led_pkg: mode encodings, start patterns and the per-step pattern function for the LED sequencer
package led_pkg;
  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;
  localparam logic [3:0] START_SHIFT = 4'b0001;
  localparam logic [3:0] START_BLINK = 4'b1111;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef struct packed {
    logic       dir;
    logic [3:0] led;
  } pat_t;
  function automatic logic [3:0] start_pattern(input logic [1:0] mode);
    return mode == MODE_BLINK ? START_BLINK : START_SHIFT;
  endfunction
  function automatic pat_t next_pattern(input logic [1:0] mode, input logic [3:0] led, input logic dir);
    logic [3:0] rl, rr, b, n;
    rl = {led[2:0], led[3]};
    rr = {led[0], led[3:1]};
    b  = dir == DIR_LEFT ? rl : rr;
    n  = mode == MODE_ROT_L ? rl : mode == MODE_ROT_R ? rr : mode == MODE_BOUNCE ? b : ~led;
    // bounce turns around on reaching either end LED
    return '{dir: mode != MODE_BOUNCE ? dir : b == 4'b1000 ? DIR_RIGHT : b == 4'b0001 ? DIR_LEFT : dir,
             led: n};
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2, lvl;
  logic [CW-1:0] cnt;
  // lvl is the accepted key level; it only flips after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        lvl   <= s2;
        press <= !s2;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 4-LED pattern sequencer with debounced mode/speed keys, step prescaler and pause
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int TICK_BASE  = 10_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int LED_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_mode_n,
  input  logic             key_speed_n,
  input  logic             pause,
  output logic [LED_W-1:0] led_o,
  output logic [1:0]       mode_o,
  output logic [1:0]       speed_o,
  output logic             step_o
);
  localparam int PW = $clog2(TICK_BASE + 1);
  logic mode_p, speed_p, dir, tick;
  logic [3:0] led;
  logic [PW-1:0] cnt, period;
  pat_t nxt;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_key (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .press(mode_p));
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_speed_key (
    .clk(clk), .rst_n(rst_n), .key_n(key_speed_n), .press(speed_p));
  assign period = PW'(TICK_BASE >> speed_o);
  assign tick   = !pause && cnt == period - 1'b1;
  assign nxt    = next_pattern(mode_o, led, dir);
  assign led_o  = LED_W'(led);
  // any key press outranks a coincident step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      led     <= START_SHIFT;
      dir     <= DIR_LEFT;
      mode_o  <= MODE_ROT_L;
      speed_o <= 2'd0;
      cnt     <= '0;
      step_o  <= 1'b0;
    end else begin
      step_o <= tick && !mode_p && !speed_p;
      cnt    <= (mode_p || speed_p || tick) ? '0 : pause ? cnt : cnt + 1'b1;
      if (speed_p) speed_o <= speed_o + 2'd1;
      if (mode_p) begin
        mode_o <= mode_o + 2'd1;
        led    <= start_pattern(mode_o + 2'd1);
        dir    <= DIR_LEFT;
      end else if (tick && !speed_p) begin
        led <= nxt.led;
        dir <= nxt.dir;
      end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed stimulus with a sequence-table reference model checked every cycle
module tb_led_pattern_ctrl;
  localparam int TB = 8;
  localparam int DB = 4;
  localparam logic [3:0] ROTL[4]  = '{4'h1, 4'h2, 4'h4, 4'h8};
  localparam logic [3:0] ROTR[4]  = '{4'h1, 4'h8, 4'h4, 4'h2};
  localparam logic [3:0] BNC[6]   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
  localparam logic [3:0] BLK[2]   = '{4'hf, 4'h0};
  localparam logic [3:0] BEXP[12] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
  localparam logic [3:0] REXP[4]  = '{4'h2, 4'h4, 4'h8, 4'h1};
  localparam int PEXP[4] = '{4, 2, 1, 8};
  logic clk = 1'b0, rst_n = 1'b0, key_mode_n = 1'b1, key_speed_n = 1'b1, pause = 1'b0;
  logic [3:0] led_o;
  logic [1:0] mode_o, speed_o;
  logic step_o;
  int checks = 0, errors = 0;
  led_pattern_ctrl #(.TICK_BASE(TB), .DEB_CYCLES(DB), .LED_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode_n(key_mode_n), .key_speed_n(key_speed_n),
    .pause(pause), .led_o(led_o), .mode_o(mode_o), .speed_o(speed_o), .step_o(step_o));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [3:0] seq(input logic [1:0] m, input int i);
    case (m)
      2'd0: return ROTL[i % 4];
      2'd1: return ROTR[i % 4];
      2'd2: return BNC[i % 6];
      default: return BLK[i % 2];
    endcase
  endfunction
  function automatic int seq_len(input logic [1:0] m);
    return m == 2'd2 ? 6 : m == 2'd3 ? 2 : 4;
  endfunction
  logic [3:0] m_led = 4'h1;
  logic [1:0] m_mode = 2'd0, m_speed = 2'd0;
  logic m_step = 1'b0;
  int m_idx = 0, m_left = TB;
  int run[2] = '{0, 0};
  logic acc[2] = '{1'b1, 1'b1};
  logic [2:0] pipe[2] = '{3'b0, 3'b0};
  // keys: a press is recognised after DB consecutive low samples and takes effect three edges later
  always @(posedge clk or negedge rst_n) begin : model
    logic pr[2];
    logic k;
    if (!rst_n) begin
      m_led = 4'h1; m_mode = 2'd0; m_speed = 2'd0; m_step = 1'b0; m_idx = 0; m_left = TB;
      for (int i = 0; i < 2; i++) begin run[i] = 0; acc[i] = 1'b1; pipe[i] = 3'b0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        k = i == 0 ? key_mode_n : key_speed_n;
        pr[i] = pipe[i][2];
        pipe[i] = {pipe[i][1:0], 1'b0};
        if (k == acc[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == DB) begin acc[i] = k; run[i] = 0; pipe[i][0] = !k; end
        end
      end
      m_step = 1'b0;
      if (pr[1]) begin m_speed++; m_left = TB >> m_speed; end
      if (pr[0]) begin m_mode++; m_idx = 0; m_left = TB >> m_speed; end
      if (!pr[0] && !pr[1] && !pause) begin
        if (m_left == 1) begin
          m_step = 1'b1;
          m_idx = (m_idx + 1) % seq_len(m_mode);
          m_left = TB >> m_speed;
        end else m_left--;
      end
      m_led = seq(m_mode, m_idx);
    end
  end
  always @(negedge clk) begin
    chk("model_led", {28'b0, led_o}, {28'b0, m_led});
    chk("model_mode", {30'b0, mode_o}, {30'b0, m_mode});
    chk("model_speed", {30'b0, speed_o}, {30'b0, m_speed});
    chk("model_step", {31'b0, step_o}, {31'b0, m_step});
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input bit spd);
    if (spd) key_speed_n = 1'b0; else key_mode_n = 1'b0;
    tick(6);
    key_speed_n = 1'b1;
    key_mode_n = 1'b1;
    tick(6);
  endtask
  task automatic wait_step(output int n);
    n = 0;
    do begin tick(1); n++; end while (!step_o && n < 40);
    chk("step_timeout", {31'b0, step_o}, 32'd1);
  endtask
  initial begin
    int n;
    tick(2);
    chk("rst_led", {28'b0, led_o}, 32'h1);
    chk("rst_mode", {30'b0, mode_o}, 32'h0);
    chk("rst_step", {31'b0, step_o}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(7);
      chk("rotl_pre_step", {31'b0, step_o}, 32'h0);
      tick(1);
      chk("rotl_led", {28'b0, led_o}, {28'b0, REXP[i]});
      chk("rotl_step", {31'b0, step_o}, 32'h1);
    end
    key_mode_n = 1'b0;
    tick(6);
    key_mode_n = 1'b1;
    tick(1);
    chk("mode1_mode", {30'b0, mode_o}, 32'h1);
    chk("mode1_led", {28'b0, led_o}, 32'h1);
    tick(8);
    chk("rotr_led", {28'b0, led_o}, 32'h8);
    chk("rotr_step", {31'b0, step_o}, 32'h1);
    press(0);
    press(0);
    chk("blink_mode", {30'b0, mode_o}, 32'h3);
    chk("blink_start", {28'b0, led_o}, 32'hf);
    tick(3);
    chk("blink_off", {28'b0, led_o}, 32'h0);
    tick(8);
    chk("blink_on", {28'b0, led_o}, 32'hf);
    tick(1);
    key_mode_n = 1'b0;
    tick(6);
    key_mode_n = 1'b1;
    tick(1);
    chk("collide_led", {28'b0, led_o}, 32'h1);
    chk("collide_mode", {30'b0, mode_o}, 32'h0);
    chk("collide_step", {31'b0, step_o}, 32'h0);
    tick(5);
    press(0);
    press(0);
    chk("bounce_mode", {30'b0, mode_o}, 32'h2);
    for (int i = 0; i < 12; i++) begin
      wait_step(n);
      chk("bounce_led", {28'b0, led_o}, {28'b0, BEXP[i]});
    end
    for (int i = 0; i < 4; i++) begin
      press(1);
      wait_step(n);
      wait_step(n);
      chk("speed_period", n, PEXP[i]);
    end
    key_speed_n = 1'b0;
    tick(3);
    key_speed_n = 1'b1;
    tick(8);
    chk("glitch_speed", {30'b0, speed_o}, 32'h0);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key_speed_n = !(i < 6);
      tick(1);
      chk("pause_step", {31'b0, step_o}, 32'h0);
    end
    chk("pause_speed", {30'b0, speed_o}, 32'h1);
    pause = 1'b0;
    press(1);
    tick(5);
    chk("pre_rst_mode", {30'b0, mode_o}, 32'h2);
    chk("pre_rst_speed", {30'b0, speed_o}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", {28'b0, led_o}, 32'h1);
    chk("arst_mode", {30'b0, mode_o}, 32'h0);
    chk("arst_speed", {30'b0, speed_o}, 32'h0);
    chk("arst_step", {31'b0, step_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_step(n);
    chk("post_rst_period", n, 8);
    chk("post_rst_led", {28'b0, led_o}, 32'h2);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
